// File: rtl/cmp_defs.sv
// Shared definitions for the pipelined magnitude comparator: default geometry,
// cascade seed values and the geometry legality check used at elaboration.
package cmp_defs;
    localparam int   DEFAULT_WIDTH = 32;
    localparam int   DEFAULT_CHUNK = 8;
    localparam logic EQ_SEED       = 1'b1;
    localparam logic GT_SEED       = 1'b0;

    function automatic bit geometry_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction
endpackage

// File: rtl/chunk_comp.sv
// One cascade cell: folds a CHUNK-bit slice into the running eq/gt flags.
// Once gt is set or eq is cleared, later (less significant) chunks cannot change the verdict.
module chunk_comp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             eq_prev,
    input  logic             gt_prev,
    output logic             eq,
    output logic             gt
);
    assign gt = gt_prev | (eq_prev & (a > b));
    assign eq = eq_prev & (a == b);
endmodule

// File: rtl/pipelined_comp.sv
// Pipelined MSB-first magnitude comparator, one CHUNK per stage, with a single global
// advance signal for valid/ready flow control. Signed mode maps to offset binary on entry.
module pipelined_comp
    import cmp_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_lt
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("pipelined_comp: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic              advance;
    logic [STAGES-1:0] valid_q, eq_q, gt_q;
    logic [STAGES-1:0] valid_d, eq_d, gt_d;
    logic [WIDTH-1:0]  a_m, b_m;

    // Flipping the sign bit turns two's complement ordering into plain unsigned ordering.
    assign a_m = in_a ^ (in_signed ? SIGN_BIT : '0);
    assign b_m = in_b ^ (in_signed ? SIGN_BIT : '0);

    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int IN_W = WIDTH - gi * CHUNK;

        logic [IN_W-1:0] op_a, op_b;
        logic            eq_prev, gt_prev;

        if (gi == 0) begin : g_head
            assign op_a        = a_m;
            assign op_b        = b_m;
            assign eq_prev     = EQ_SEED;
            assign gt_prev     = GT_SEED;
            assign valid_d[gi] = in_valid;
        end else begin : g_body
            assign op_a        = g_stage[gi-1].g_rem.a_q;
            assign op_b        = g_stage[gi-1].g_rem.b_q;
            assign eq_prev     = eq_q[gi-1];
            assign gt_prev     = gt_q[gi-1];
            assign valid_d[gi] = valid_q[gi-1];
        end

        chunk_comp #(.CHUNK(CHUNK)) u_chunk (
            .a       (op_a[IN_W-1 -: CHUNK]),
            .b       (op_b[IN_W-1 -: CHUNK]),
            .eq_prev (eq_prev),
            .gt_prev (gt_prev),
            .eq      (eq_d[gi]),
            .gt      (gt_d[gi])
        );

        // Only the not-yet-compared low bits travel on; the last stage carries none.
        if (gi < STAGES - 1) begin : g_rem
            logic [IN_W-CHUNK-1:0] a_q, b_q;

            always_ff @(posedge clock) begin
                if (advance && valid_d[gi]) begin
                    a_q <= op_a[IN_W-CHUNK-1:0];
                    b_q <= op_b[IN_W-CHUNK-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '0;
            eq_q    <= '0;
            gt_q    <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (valid_d[k]) begin
                    eq_q[k] <= eq_d[k];
                    gt_q[k] <= gt_d[k];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_eq    = out_valid & eq_q[STAGES-1];
    assign out_gt    = out_valid & gt_q[STAGES-1];
    assign out_lt    = out_valid & !eq_q[STAGES-1] & !gt_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_comp.sv
// Self-checking bench: scoreboard of expected {eq,gt,lt} pushed on accept, popped on drain,
// plus latency checks on CHUNK=8, CHUNK=32 and CHUNK=1 instances.
module tb_pipelined_comp;
    localparam int W = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n, in_valid, in_signed, out_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_ready, out_valid, out_eq, out_gt, out_lt;

    logic         c_valid;
    logic [W-1:0] c_a, c_b;
    logic         w_ready, w_valid, w_eq, w_gt, w_lt;
    logic         s_ready, s_valid, s_eq, s_gt, s_lt;

    pipelined_comp #(.WIDTH(W), .CHUNK(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_eq(out_eq), .out_gt(out_gt), .out_lt(out_lt)
    );

    pipelined_comp #(.WIDTH(W), .CHUNK(32)) dut_wide (
        .clock(clock), .reset_n(reset_n), .in_valid(c_valid), .in_ready(w_ready),
        .in_a(c_a), .in_b(c_b), .in_signed(1'b0), .out_valid(w_valid),
        .out_ready(1'b1), .out_eq(w_eq), .out_gt(w_gt), .out_lt(w_lt)
    );

    pipelined_comp #(.WIDTH(W), .CHUNK(1)) dut_serial (
        .clock(clock), .reset_n(reset_n), .in_valid(c_valid), .in_ready(s_ready),
        .in_a(c_a), .in_b(c_b), .in_signed(1'b0), .out_valid(s_valid),
        .out_ready(1'b1), .out_eq(s_eq), .out_gt(s_gt), .out_lt(s_lt)
    );

    int         checks = 0;
    int         errors = 0;
    int         tick_no = 0;
    int         pops = 0;
    bit         accepted;
    logic [2:0] sb[$];
    int         pop_ticks[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: widen to 33 bits with sign or zero extension and compare as signed integers.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [W:0] sa, sb_v;
        sa   = s ? {a[W-1], a} : {1'b0, a};
        sb_v = s ? {b[W-1], b} : {1'b0, b};
        if (sa == sb_v)     return 3'b100;
        else if (sa > sb_v) return 3'b010;
        else                return 3'b001;
    endfunction

    task automatic tick();
        logic [2:0] exp;
        @(negedge clock);
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back(model(in_a, in_b, in_signed));
        if (out_valid && out_ready) begin
            check("result_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                pops++;
                pop_ticks.push_back(tick_no);
                $display("result %0d at tick %0d: eq=%b gt=%b lt=%b (want %b)",
                         pops, tick_no, out_eq, out_gt, out_lt, exp);
                check("result", {out_eq, out_gt, out_lt}, exp);
            end
        end else if (!out_valid) begin
            check("idle_flags", {out_eq, out_gt, out_lt}, 3'b000);
        end
        @(posedge clock);
        #1;
        tick_no++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb.size() > 0 || out_valid); i++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    logic [W-1:0] da[7];
    logic [W-1:0] db[7];
    logic         ds[7];
    int           lat, lat_w, lat_s, n_acc, span;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        out_ready = 1'b0; c_valid = 1'b0; c_a = '0; c_b = '0;

        // Reset with out_ready low: in_ready can only be 1 if out_valid was cleared.
        tick(); tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {out_eq, out_gt, out_lt}, 3'b000);
        reset_n = 1'b1;
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid_after", out_valid, 0);
        out_ready = 1'b1;

        // Single pair: latency counted in edges including the accepting one.
        in_a = 32'h1234_5678; in_b = 32'h1234_5679; in_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency_main", lat, 4);
        check("first_lt", {out_eq, out_gt, out_lt}, 3'b001);
        drain();

        // Signed/unsigned directed pairs, back to back.
        da = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h01FF_FFFF, 32'h1234_0000};
        db = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0200_0000, 32'h1234_0000};
        ds = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            in_a = da[i]; in_b = db[i]; in_signed = ds[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Ten random pairs on consecutive cycles must drain on consecutive cycles.
        pop_ticks.delete();
        for (int i = 0; i < 10; i++) begin
            in_a = $urandom;
            case (i % 3)
                0:       in_b = in_a;
                1:       in_b = in_a ^ (32'h1 << $urandom_range(31, 0));
                default: in_b = $urandom;
            endcase
            in_signed = 1'($urandom_range(1, 0));
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("b2b_count", pop_ticks.size(), 10);
        span = (pop_ticks.size() > 0) ? pop_ticks[pop_ticks.size()-1] - pop_ticks[0] : -1;
        check("b2b_consecutive", span, 9);

        // Backpressure: fill with out_ready low, hold 5 cycles, then release.
        out_ready = 1'b0; n_acc = 0;
        in_a = $urandom; in_b = $urandom; in_signed = 1'b1; in_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (accepted) begin
                n_acc++;
                in_a = $urandom; in_b = (t == 1) ? in_a : $urandom; in_signed = 1'($urandom_range(1, 0));
            end
        end
        check("bp_accepted", n_acc, 4);
        for (int t = 0; t < 5; t++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_frozen", {out_eq, out_gt, out_lt}, (sb.size() > 0) ? sb[0] : 3'bxxx);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        pop_ticks.delete();
        drain();
        check("bp_drain_count", pop_ticks.size(), 4);

        // Reset mid-flight: three pairs in the pipe, none may ever emerge.
        for (int i = 0; i < 3; i++) begin
            in_a = $urandom; in_b = $urandom; in_signed = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            check("rst_no_stale", out_valid, 0);
            tick();
        end
        check("rst_in_ready", in_ready, 1);

        // Corner geometries: CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
        check("wide_in_ready", w_ready, 1);
        check("serial_in_ready", s_ready, 1);
        c_a = 32'h0000_0000; c_b = 32'hFFFF_FFFF; c_valid = 1'b1;
        @(posedge clock); #1;
        c_valid = 1'b0;
        lat_w = 0; lat_s = 0;
        for (int e = 1; e <= 40; e++) begin
            if (w_valid && lat_w == 0) begin
                lat_w = e;
                check("wide_lt", {w_eq, w_gt, w_lt}, 3'b001);
            end
            if (s_valid && lat_s == 0) begin
                lat_s = e;
                check("serial_lt", {s_eq, s_gt, s_lt}, 3'b001);
            end
            @(posedge clock); #1;
        end
        check("latency_wide", lat_w, 1);
        check("latency_serial", lat_s, 32);

        check("sb_final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
